// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: sequencing controller for MULT/MULTU and owner of the HI/LO registers.
// An iterative shift-add multiply runs over WIDTH/BITS_PER_CYCLE CALC cycles, then FIX commits the
// 64-bit product to {hi,lo} together with a one-cycle done pulse.
// Ports: start/is_signed/op_a/op_b carry the multiply request.
// Ports: busy/start_stall/done report status; start_stall tells upstream to hold the request.
// Ports: mf_req/mf_sel_hi/mf_stall/mf_data form the MFHI/MFLO read port.
// Ports: hi/lo are the architectural registers.
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide WIDTH.
module hilo_mult_ctrl #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             start_stall,
  output logic             done,
  input  logic             mf_req,
  input  logic             mf_sel_hi,
  output logic             mf_stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;   // multiplicand, pre-shifted to the weight of the current multiplier LSB
  logic [WIDTH-1:0]   mplier;  // multiplier, consumed from the LSB end
  logic               neg;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               last_step;

  // Magnitudes: the most-negative value negates to itself, which read as unsigned is the
  // correct magnitude, so no overflow handling is needed.
  assign a_abs     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_abs     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign last_step = (cnt == CW'(STEPS - 1));

  // Sum of the partial products for the BITS_PER_CYCLE multiplier bits retired this cycle.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; the read port is purely combinational so a read in the done cycle sees the
  // freshly committed product.
  always_comb begin
    busy        = (state != IDLE);
    start_stall = start & busy;
    mf_stall    = mf_req & busy;
    mf_data     = '0;
    if (mf_req && !busy) mf_data = mf_sel_hi ? hi : lo;
  end

  // Datapath and HI/LO. A reset mid-multiply simply discards the partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_abs};
            mplier <= b_abs;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc + pp;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          {hi, lo} <= neg ? -acc : acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: three instances (BITS_PER_CYCLE = 1, 2, 4) share the same stimulus.
// A latency/product model is compared against every output of every instance on each falling edge.
// Directed vectors pin the model with literal expectations.
module tb_hilo_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed, mf_req, mf_sel_hi;
  logic [31:0] op_a, op_b;

  logic        o_busy[3], o_sstall[3], o_done[3], o_mfstall[3];
  logic [31:0] o_mfdata[3], o_hi[3], o_lo[3];

  int checks = 0;
  int errors = 0;

  // Edges from the accepting edge to the done edge: WIDTH/BPC + 1
  int LAT[3]  = '{33, 17, 9};
  int BPCV[3] = '{1, 2, 4};

  always #5 clk = ~clk;

  hilo_mult_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(o_busy[0]), .start_stall(o_sstall[0]), .done(o_done[0]), .mf_req(mf_req),
    .mf_sel_hi(mf_sel_hi), .mf_stall(o_mfstall[0]), .mf_data(o_mfdata[0]), .hi(o_hi[0]), .lo(o_lo[0]));
  hilo_mult_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(2)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(o_busy[1]), .start_stall(o_sstall[1]), .done(o_done[1]), .mf_req(mf_req),
    .mf_sel_hi(mf_sel_hi), .mf_stall(o_mfstall[1]), .mf_data(o_mfdata[1]), .hi(o_hi[1]), .lo(o_lo[1]));
  hilo_mult_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(o_busy[2]), .start_stall(o_sstall[2]), .done(o_done[2]), .mf_req(mf_req),
    .mf_sel_hi(mf_sel_hi), .mf_stall(o_mfstall[2]), .mf_data(o_mfdata[2]), .hi(o_hi[2]), .lo(o_lo[2]));

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (bpc=%0d) t=%0t: got %h expected %h", nm, BPCV[k], $time, act, exp);
    end
  endtask

  // Model: per instance, the number of edges left until the product lands, plus HI/LO.
  int          rem[3]  = '{0, 0, 0};
  logic [31:0] m_hi[3] = '{0, 0, 0};
  logic [31:0] m_lo[3] = '{0, 0, 0};
  logic        m_done[3] = '{0, 0, 0};
  logic [63:0] pend[3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        rem[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_done[k] = 0;
      end else begin
        m_done[k] = 1'b0;
        if (rem[k] > 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            {m_hi[k], m_lo[k]} = pend[k];
            m_done[k] = 1'b1;
          end
        end else if (start) begin
          pend[k] = ref_prod(is_signed, op_a, op_b);
          rem[k]  = LAT[k];
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin : cmp
    logic        mb;
    logic [31:0] e_mf;
    for (int k = 0; k < 3; k++) begin
      mb   = (rem[k] > 0);
      e_mf = (mf_req && !mb) ? (mf_sel_hi ? m_hi[k] : m_lo[k]) : 32'h0;
      chk("busy", k, {31'h0, o_busy[k]}, {31'h0, mb});
      chk("done", k, {31'h0, o_done[k]}, {31'h0, m_done[k]});
      chk("start_stall", k, {31'h0, o_sstall[k]}, {31'h0, start & mb});
      chk("mf_stall", k, {31'h0, o_mfstall[k]}, {31'h0, mf_req & mb});
      chk("mf_data", k, o_mfdata[k], e_mf);
      chk("hi", k, o_hi[k], m_hi[k]);
      chk("lo", k, o_lo[k], m_lo[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one start for one cycle, then scrambles the operand inputs.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    tick();
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    tick();
    start = 1'b0; is_signed = 1'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  // Waits for every instance's done pulse; base = edges already elapsed since acceptance.
  // Returns at the falling edge of the slowest instance's done cycle.
  task automatic wait_done(input int base);
    int lat[3];
    lat = '{-1, -1, -1};
    for (int it = 0; it < 100; it++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (o_done[k] && lat[k] < 0) lat[k] = base + it;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    for (int k = 0; k < 3; k++) chk("latency", k, lat[k], LAT[k]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    mf_req = 1'b1; mf_sel_hi = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hi", 0, o_hi[0], 32'h0);
    chk("rst_lo", 0, o_lo[0], 32'h0);
    chk("rst_busy", 0, {31'h0, o_busy[0]}, 32'h0);
    chk("rst_mf_data", 0, o_mfdata[0], 32'h0);
    tick();
    rst_n = 1'b1; mf_req = 1'b0;

    // 6x7 unsigned with a read held pending and a second start mid-CALC
    mf_req = 1'b1; mf_sel_hi = 1'b0;
    issue(1'b0, 32'd6, 32'd7);
    repeat (4) tick();
    start = 1'b1; op_a = 32'd100; op_b = 32'd100;
    @(negedge clk);
    chk("mid_start_stall", 0, {31'h0, o_sstall[0]}, 32'h1);
    chk("mid_mf_stall", 0, {31'h0, o_mfstall[0]}, 32'h1);
    chk("mid_mf_data", 0, o_mfdata[0], 32'h0);
    tick();
    start = 1'b0;
    wait_done(5);
    chk("u6x7_hi", 0, o_hi[0], 32'h0);
    chk("u6x7_lo", 0, o_lo[0], 32'h2A);
    chk("done_mf_stall", 0, {31'h0, o_mfstall[0]}, 32'h0);
    chk("done_mf_data", 0, o_mfdata[0], 32'h2A);

    // Back-to-back: start presented in the done cycle, signed -3x5
    #1;
    start = 1'b1; is_signed = 1'b1; op_a = 32'hFFFF_FFFD; op_b = 32'd5; mf_req = 1'b0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 0, {31'h0, o_busy[0]}, 32'h1);
    wait_done(1);
    chk("s-3x5_hi", 0, o_hi[0], 32'hFFFF_FFFF);
    chk("s-3x5_lo", 0, o_lo[0], 32'hFFFF_FFF1);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);
    chk("umax_hi", 0, o_hi[0], 32'hFFFF_FFFE);
    chk("umax_lo", 0, o_lo[0], 32'h0000_0001);

    issue(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(0);
    chk("smin_hi", 0, o_hi[0], 32'h4000_0000);
    chk("smin_lo", 0, o_lo[0], 32'h0);

    // Reset in the middle of a multiply
    issue(1'b1, 32'd7, 32'd9);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, {31'h0, o_busy[0]}, 32'h0);
    chk("arst_hi", 0, o_hi[0], 32'h0);
    chk("arst_lo", 0, o_lo[0], 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("arst_no_result", 0, o_lo[0], 32'h0);
    issue(1'b0, 32'd2, 32'd3);
    wait_done(0);
    chk("post_rst_lo", 0, o_lo[0], 32'd6);
    chk("post_rst_hi", 0, o_hi[0], 32'd0);

    // Random sweep, alternating HI/LO reads, all three widths against the model
    for (int n = 0; n < 8; n++) begin
      mf_req = 1'($urandom); mf_sel_hi = 1'($urandom);
      issue(1'($urandom), $urandom, $urandom);
      wait_done(0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequencing controller for the MIPS MULT/MULTU path (ALU selects C_MULT / C_MUL_U) and owner of the architectural HI/LO registers.
- Accepts a multiply request from decode/execute and runs an iterative shift-add multiply over several cycles.
- Commits the 64-bit product to HI/LO.
- Arbitrates MFHI/MFLO reads, stalling them while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle. Legal values: 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  multiply request (C_MULT or C_MUL_U issued).
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- op_a  in  WIDTH  multiplicand (rs).
- op_b  in  WIDTH  multiplier (rt).
- busy  out  1  multiply in flight (state != IDLE).
- start_stall  out  1  start & busy; upstream must hold the request.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- mf_req  in  1  MFHI/MFLO read request.
- mf_sel_hi  in  1  1 = read HI, 0 = read LO.
- mf_stall  out  1  mf_req & busy.
- mf_data  out  WIDTH  selected HI or LO; 0 when mf_stall=1 or mf_req=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=lo=0; busy=done=0; counter, accumulator and operand latches = 0.
- All outputs read 0 during reset.
- Reset mid-multiply aborts the operation with no HI/LO update.
- FSM has three states: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1, latch |op_a| and |op_b|. Absolute values apply only if is_signed=1; otherwise the raw bits are latched.
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Clear the 2*WIDTH accumulator; set cnt=0; go to CALC.
- CALC:
  - Each edge retires BITS_PER_CYCLE multiplier LSBs: add the shifted partial products into the accumulator and shift the multiplier right.
  - cnt increments each edge.
  - On the edge where cnt == WIDTH/BITS_PER_CYCLE - 1, go to FIX.
- FIX:
  - On the edge: {hi,lo} <= neg ? -acc : acc, with the negation modulo 2^(2*WIDTH).
  - done <= 1 for exactly one cycle; go to IDLE.
- Magnitude of the most-negative value (0x80000000) is the unsigned 2^31; no overflow handling is needed.
- Latency: start sampled at edge 0 → done high and new HI/LO visible from edge N+1, where N = WIDTH/BITS_PER_CYCLE (default 33 cycles).
- busy:
  - Goes high the cycle after start is accepted and stays high through CALC and FIX.
  - Is low in the done cycle.
- Back-to-back: a start in the done cycle is accepted, since state is IDLE.
- Start while busy:
  - Ignored; operands are not re-latched.
  - start_stall=1 combinationally.
  - No queueing: the requester must re-present start.
- MF reads are combinational:
  - If busy, mf_stall=1 and mf_data=0.
  - Otherwise mf_data = mf_sel_hi ? hi : lo.
- Reads in the done cycle return the new product.
- Same-cycle start & mf_req in IDLE: the read returns the old HI/LO with no stall, and start is accepted.
- hi/lo change only in the FIX→IDLE transition or on reset.
- is_signed, op_a and op_b are ignored except on the accepting edge.

Test Plan:
- Unsigned 6×7: start, is_signed=0, op_a=6, op_b=7 → busy for 33 cycles; done pulse at cycle 33; hi=0x00000000, lo=0x0000002A.
- Signed −3×5: op_a=0xFFFFFFFD, op_b=5, is_signed=1 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Corner values (two operations):
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0x00000000.
- Hazards during a busy multiply:
  - mf_req=1 mid-CALC → mf_stall=1, mf_data=0.
  - Second start mid-CALC → start_stall=1 and the result is unaffected.
  - In the done cycle, mf_req with mf_sel_hi=0 → mf_stall=0, mf_data=new lo.
  - A start in the done cycle is accepted (busy next cycle).
- Reset mid-op: after a completed product (hi/lo nonzero), start a new multiply and drop rst_n at cycle 10 → asynchronously busy=0, hi=lo=0, no done pulse.
  - After release, 2×3 completes normally with lo=6.
- Sweep BITS_PER_CYCLE=1, 2, 4 with random signed and unsigned operands against a reference model → latency = WIDTH/BPC + 1 cycles and bit-exact HI/LO.
